phase_speed_avg: RTL and testbench

Multi-channel successor to the single-channel phase-to-speed averager in the wind-direction datapath. Accepts signed phase samples tagged with a channel index, block-averages 2^LOG2N samples per channel in independent accumulators, and scales each average to a signed speed word through a 3-stage registered pipeline with saturation. Sits between the per-transducer phase detectors and the speed/direction combiner; the output is a one-cycle valid strobe carrying the channel tag.

---
 rtl/phase_speed_avg.sv | 152 +++++++++++++++
 tb/tb_phase_speed_avg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_speed_avg.sv
// Multi-channel phase block averager: sums 2^LOG2N samples per channel, then
// averages, scales and saturates the result to a signed speed word over three registered stages.
module phase_speed_avg #(
    parameter int PHASE_W = 19,
    parameter int SPEED_W = 16,
    parameter int CH      = 2,
    parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1,
    parameter int LOG2N   = 7,
    parameter int SCALE   = 18026,
    parameter int SHIFT   = 17
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CH_W-1:0]           in_ch,
    input  logic signed [PHASE_W-1:0] phase,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic signed [SPEED_W-1:0] speed,
    output logic                      sat
);

    localparam int ACC_W  = PHASE_W + LOG2N;
    localparam int CNT_W  = LOG2N + 1;
    localparam int PROD_W = PHASE_W + 17;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << LOG2N) - 1);
    localparam logic [CH_W:0]            CH_LIM   = (CH_W + 1)'(CH);
    localparam logic [16:0]              SCALE_U  = 17'(SCALE);
    localparam logic signed [PROD_W-1:0] SPD_MAX  = PROD_W'((1 << (SPEED_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SPD_MIN  = ~SPD_MAX;

    logic signed [ACC_W-1:0] acc_q [CH];
    logic [CNT_W-1:0]        cnt_q [CH];

    logic                      accept;
    logic                      done;
    logic signed [ACC_W-1:0]   sel_acc;
    logic [CNT_W-1:0]          sel_cnt;
    logic signed [ACC_W-1:0]   sum_d;
    logic signed [PHASE_W-1:0] avg_d;

    logic                      s1_valid_q;
    logic [CH_W-1:0]           s1_ch_q;
    logic signed [PHASE_W-1:0] s1_avg_q;

    logic                      s2_valid_q;
    logic [CH_W-1:0]           s2_ch_q;
    logic signed [PROD_W-1:0]  s2_prod_q;
    logic signed [PROD_W-1:0]  prod_d;

    logic signed [PROD_W-1:0]  q_d;
    logic signed [SPEED_W-1:0] speed_d;
    logic                      sat_d;

    logic                      out_valid_q;
    logic [CH_W-1:0]           out_ch_q;
    logic signed [SPEED_W-1:0] speed_q;
    logic                      sat_q;

    // Channel select by loop so out-of-range tags never index past the arrays.
    always_comb begin
        accept  = in_valid && ({1'b0, in_ch} < CH_LIM);
        sel_acc = '0;
        sel_cnt = '0;
        for (int c = 0; c < CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                sel_acc = acc_q[c];
                sel_cnt = cnt_q[c];
            end
        end
        sum_d = sel_acc + ACC_W'(phase);
        done  = accept && (sel_cnt == CNT_LAST);
        avg_d = PHASE_W'(sum_d >>> LOG2N);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CH; c++) begin
                if (in_ch == CH_W'(c)) begin
                    // Completing sample clears the slot so the next block starts with no gap.
                    if (done) begin
                        acc_q[c] <= '0;
                        cnt_q[c] <= '0;
                    end else begin
                        acc_q[c] <= sum_d;
                        cnt_q[c] <= sel_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        prod_d = $signed({{17{s1_avg_q[PHASE_W-1]}}, s1_avg_q}) *
                 $signed({{PHASE_W{1'b0}}, SCALE_U});
        q_d    = s2_prod_q >>> SHIFT;
        if (q_d > SPD_MAX) begin
            speed_d = SPEED_W'(SPD_MAX);
            sat_d   = 1'b1;
        end else if (q_d < SPD_MIN) begin
            speed_d = SPEED_W'(SPD_MIN);
            sat_d   = 1'b1;
        end else begin
            speed_d = SPEED_W'(q_d);
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_avg_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            speed_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q  <= done;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (done) begin
                s1_ch_q  <= in_ch;
                s1_avg_q <= avg_d;
            end
            if (s1_valid_q) begin
                s2_ch_q   <= s1_ch_q;
                s2_prod_q <= prod_d;
            end
            // Result fields hold between strobes.
            if (s2_valid_q) begin
                out_ch_q <= s2_ch_q;
                speed_q  <= speed_d;
                sat_q    <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign speed     = speed_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_phase_speed_avg.sv
// Directed bench: a 3-channel LOG2N=2 instance for block averaging and reset,
// and a 1-channel LOG2N=0 instance for back-to-back throughput.
module tb_phase_speed_avg;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Instance A: CH=3, LOG2N=2
    logic               a_in_valid = 1'b0;
    logic [1:0]         a_in_ch    = '0;
    logic signed [18:0] a_phase    = '0;
    logic               a_out_valid;
    logic [1:0]         a_out_ch;
    logic signed [15:0] a_speed;
    logic               a_sat;

    // Instance B: CH=1, LOG2N=0
    logic               b_in_valid = 1'b0;
    logic [0:0]         b_in_ch    = '0;
    logic signed [18:0] b_phase    = '0;
    logic               b_out_valid;
    logic [0:0]         b_out_ch;
    logic signed [15:0] b_speed;
    logic               b_sat;

    phase_speed_avg #(.CH(3), .LOG2N(2)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ch(a_in_ch), .phase(a_phase),
        .out_valid(a_out_valid), .out_ch(a_out_ch), .speed(a_speed), .sat(a_sat)
    );

    phase_speed_avg #(.CH(1), .LOG2N(0)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ch(b_in_ch), .phase(b_phase),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .speed(b_speed), .sat(b_sat)
    );

    typedef struct {
        logic [1:0]         ch;
        logic signed [18:0] p0, p1, p2, p3;
        logic signed [15:0] speed;
        logic               sat;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    // Scoreboard word for instance A: {out_ch, speed, sat}
    logic [18:0] exp_q [$];
    int a_strobes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] ch, input logic signed [18:0] p);
        a_in_valid = v;
        a_in_ch    = ch;
        a_phase    = p;
    endtask

    always @(negedge clock) begin
        if (a_out_valid) begin
            a_strobes++;
            if (exp_q.size() == 0) begin
                chk("sb_a_unexpected_strobe", longint'(a_out_valid), 0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                chk("sb_a_result", longint'({a_out_ch, a_speed, a_sat}), longint'(e));
            end
        end
    end

    // Four samples on consecutive cycles, then exact-latency and hold checks.
    task automatic run_block(input logic [1:0] ch, input logic signed [18:0] p0, input logic signed [18:0] p1,
                             input logic signed [18:0] p2, input logic signed [18:0] p3,
                             input logic signed [15:0] es, input logic esat, input string tag);
        logic signed [18:0] ps [4];
        ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
        exp_q.push_back({ch, es, esat});
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, ch, ps[k]);
            tick();
            chk({tag, "_early_valid"}, longint'(a_out_valid), 0);
        end
        drive_a(1'b0, 2'd0, '0);
        tick();
        chk({tag, "_t2_valid"}, longint'(a_out_valid), 0);
        tick();
        chk({tag, "_t3_valid"}, longint'(a_out_valid), 1);
        chk({tag, "_ch"}, longint'(a_out_ch), longint'(ch));
        chk({tag, "_speed"}, longint'(a_speed), longint'(es));
        chk({tag, "_sat"}, longint'(a_sat), longint'(esat));
        tick();
        chk({tag, "_strobe_len"}, longint'(a_out_valid), 0);
        chk({tag, "_hold_speed"}, longint'(a_speed), longint'(es));
    endtask

    initial begin
        logic signed [18:0] b_ph [4];
        logic signed [15:0] b_sp [4];
        logic               b_st [4];
        int                 s0;

        vecs[0] = '{ch: 2'd0, p0: 19'sd1000, p1: 19'sd1000, p2: 19'sd1000, p3: 19'sd1000, speed: 16'sd137, sat: 1'b0};
        vecs[1] = '{ch: 2'd0, p0: -19'sd1000, p1: -19'sd1000, p2: -19'sd1000, p3: -19'sd1000, speed: -16'sd138, sat: 1'b0};
        vecs[2] = '{ch: 2'd0, p0: 19'sd1, p1: 19'sd0, p2: 19'sd0, p3: 19'sd0, speed: 16'sd0, sat: 1'b0};
        vecs[3] = '{ch: 2'd0, p0: 19'sd262143, p1: 19'sd262143, p2: 19'sd262143, p3: 19'sd262143, speed: 16'sd32767, sat: 1'b1};
        vecs[4] = '{ch: 2'd0, p0: -19'sd262144, p1: -19'sd262144, p2: -19'sd262144, p3: -19'sd262144, speed: -16'sd32768, sat: 1'b1};
        vecs[5] = '{ch: 2'd2, p0: 19'sd1000, p1: 19'sd2000, p2: -19'sd500, p3: 19'sd3, speed: 16'sd85, sat: 1'b0};
        vecs[6] = '{ch: 2'd1, p0: -19'sd3, p1: 19'sd0, p2: 19'sd0, p3: 19'sd0, speed: -16'sd1, sat: 1'b0};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_a_valid", longint'(a_out_valid), 0);
        chk("rst_a_speed", longint'(a_speed), 0);
        chk("rst_a_ch", longint'(a_out_ch), 0);
        chk("rst_a_sat", longint'(a_sat), 0);
        chk("rst_b_valid", longint'(b_out_valid), 0);
        chk("rst_b_speed", longint'(b_speed), 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_block(vecs[i].ch, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3,
                      vecs[i].speed, vecs[i].sat, $sformatf("vec%0d", i));
        end

        // Reset with ch0 three samples in and a ch1 result sitting in stage 2.
        for (int k = 0; k < 3; k++) begin drive_a(1'b1, 2'd1, -19'sd1000); tick(); end
        for (int k = 0; k < 3; k++) begin drive_a(1'b1, 2'd0, 19'sd1000); tick(); end
        drive_a(1'b1, 2'd1, -19'sd1000);
        tick();
        drive_a(1'b0, 2'd0, '0);
        tick();
        reset = 1'b1;
        drive_a(1'b1, 2'd0, 19'sd5000);
        tick();
        chk("midrst_valid", longint'(a_out_valid), 0);
        chk("midrst_speed", longint'(a_speed), 0);
        chk("midrst_ch", longint'(a_out_ch), 0);
        chk("midrst_sat", longint'(a_sat), 0);
        drive_a(1'b0, 2'd0, '0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("postrst_no_strobe", longint'(a_out_valid), 0);
        end
        run_block(2'd0, 19'sd1000, 19'sd1000, 19'sd1000, 19'sd1000, 16'sd137, 1'b0, "postrst");

        // Interleaved channels with out-of-range tag and idle gaps.
        s0 = a_strobes;
        exp_q.push_back({2'd0, 16'sd137, 1'b0});
        exp_q.push_back({2'd1, -16'sd138, 1'b0});
        exp_q.push_back({2'd2, 16'sd0, 1'b0});
        for (int r = 0; r < 4; r++) begin
            drive_a(1'b1, 2'd0, 19'sd1000);  tick();
            drive_a(1'b1, 2'd1, -19'sd1000); tick();
            drive_a(1'b1, 2'd3, 19'sd5000);  tick();
            drive_a(1'b1, 2'd2, 19'sd0);     tick();
            drive_a(1'b0, 2'd0, '0);         tick();
        end
        for (int k = 0; k < 6; k++) tick();
        chk("ilv_strobe_count", longint'(a_strobes - s0), 3);

        // Instance B: back-to-back completions, one result per cycle.
        b_ph[0] = 19'sd0;   b_sp[0] = 16'sd0;     b_st[0] = 1'b0;
        b_ph[1] = 19'sd1000;  b_sp[1] = 16'sd137;   b_st[1] = 1'b0;
        b_ph[2] = -19'sd1000; b_sp[2] = -16'sd138;  b_st[2] = 1'b0;
        b_ph[3] = 19'sd262143; b_sp[3] = 16'sd32767; b_st[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_in_valid = (i < 4);
            b_phase    = (i < 4) ? b_ph[i] : '0;
            b_in_ch    = '0;
            tick();
            if (i >= 2 && i < 6) begin
                chk($sformatf("b_valid%0d", i - 2), longint'(b_out_valid), 1);
                chk($sformatf("b_speed%0d", i - 2), longint'(b_speed), longint'(b_sp[i - 2]));
                chk($sformatf("b_sat%0d", i - 2), longint'(b_sat), longint'(b_st[i - 2]));
                chk($sformatf("b_ch%0d", i - 2), longint'(b_out_ch), 0);
            end else begin
                chk($sformatf("b_idle%0d", i), longint'(b_out_valid), 0);
            end
        end

        chk("a_total_strobes", longint'(a_strobes), 11);
        chk("a_queue_drained", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
